// File: rtl/arbiter8_rr.sv
// Round-robin arbiter for eight requesters sharing one decoded resource.
// Grants hold until done, abandonment, or HOLD_MAX timeout, then rotate.
module arbiter8_rr #(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [2:0] gnt_idx,
  output logic       gnt_en,
  output logic [7:0] gnt,
  output logic       tmo
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  localparam logic [7:0] HOLD_LAST =
    (HOLD_MAX == 0) ? 8'd0 : 8'(HOLD_MAX - 1);

  state_t     state_q;
  logic [2:0] ptr_q;
  logic [7:0] cnt_q;
  logic [2:0] idx_q;
  logic       en_q;
  logic [7:0] gnt_q;
  logic       tmo_q;

  logic       hit;
  logic [2:0] win_d;
  logic [2:0] cand;
  logic       hold_exp;
  logic       rel;

  // Scan from the farthest offset down so the nearest set bit wins.
  always_comb begin
    hit   = 1'b0;
    win_d = ptr_q;
    cand  = ptr_q;
    for (int i = 7; i >= 0; i--) begin
      cand = ptr_q + 3'(i);
      if (req[cand]) begin
        hit   = 1'b1;
        win_d = cand;
      end
    end
  end

  assign hold_exp = (HOLD_MAX != 0) && (cnt_q == HOLD_LAST);
  assign rel      = done || !req[idx_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      en_q    <= 1'b0;
      gnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          tmo_q <= 1'b0;
          if (hit) begin
            state_q <= GRANT;
            idx_q   <= win_d;
            en_q    <= 1'b1;
            gnt_q   <= 8'b1 << win_d;
            cnt_q   <= '0;
            ptr_q   <= win_d + 3'd1;
          end
        end
        GRANT: begin
          if (rel || hold_exp) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            gnt_q   <= '0;
            tmo_q   <= !rel;
          end else if (cnt_q != 8'hFF) begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
      endcase
    end
  end

  assign gnt_idx = idx_q;
  assign gnt_en  = en_q;
  assign gnt     = gnt_q;
  assign tmo     = tmo_q;

endmodule

// File: tb/tb_arbiter8_rr.sv
// Randomized and directed bench for arbiter8_rr.
// Reference tracks holder, rotation start and elapsed grant cycles.
module tb_arbiter8_rr;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = '0;
  logic       done = 1'b0;
  logic [2:0] gnt_idx;
  logic       gnt_en;
  logic [7:0] gnt;
  logic       tmo;

  int checks = 0;
  int failures = 0;

  bit m_busy;
  int m_idx;
  int m_next;
  int m_age;
  bit m_tmo;

  arbiter8_rr #(.HOLD_MAX(HOLD)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .done   (done),
    .gnt_idx(gnt_idx),
    .gnt_en (gnt_en),
    .gnt    (gnt),
    .tmo    (tmo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [7:0] r, input int from);
    for (int i = 0; i < 8; i++)
      if (r[(from + i) % 8]) return (from + i) % 8;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0;
    m_idx  = 0;
    m_next = 0;
    m_age  = 0;
    m_tmo  = 0;
  endtask

  task automatic model_edge(input logic [7:0] r, input logic d);
    int k;
    if (!m_busy) begin
      m_tmo = 0;
      k = pick(r, m_next);
      if (k >= 0) begin
        m_busy = 1;
        m_idx  = k;
        m_next = (k + 1) % 8;
        m_age  = 1;
      end
    end else if (d || !r[m_idx]) begin
      m_busy = 0;
      m_tmo  = 0;
    end else if (HOLD > 0 && m_age == HOLD) begin
      m_busy = 0;
      m_tmo  = 1;
    end else begin
      m_age++;
    end
  endtask

  task automatic compare_all(input string tag);
    logic [7:0] eg;
    eg = m_busy ? 8'(1 << m_idx) : 8'h00;
    check({tag, ".en"}, 32'(gnt_en), 32'(m_busy));
    check({tag, ".idx"}, 32'(gnt_idx), 32'(m_idx));
    check({tag, ".gnt"}, 32'(gnt), 32'(eg));
    check({tag, ".tmo"}, 32'(tmo), 32'(m_tmo));
  endtask

  task automatic step(input string tag,
                      input logic [7:0] r,
                      input logic d);
    req  = r;
    done = d;
    @(posedge clk);
    model_edge(r, d);
    #1;
    compare_all(tag);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < n; i++) begin
      req  = 8'($urandom);
      done = 1'($urandom);
      @(posedge clk);
      #1;
      compare_all("rst");
    end
    req  = '0;
    done = 1'b0;
    rst  = 1'b0;
  endtask

  logic [7:0] cur;

  initial begin
    model_reset();
    #1;
    do_reset(3);
    step("idle", 8'h00, 1'b1);
    step("idle", 8'h00, 1'b0);

    // Single requester, done in the third grant cycle.
    step("single", 8'h20, 1'b0);
    check("single.idx5", 32'(gnt_idx), 32'd5);
    step("single", 8'h20, 1'b0);
    step("single", 8'h20, 1'b0);
    step("single", 8'h20, 1'b1);
    step("single", 8'h20, 1'b0);
    step("single", 8'h20, 1'b1);

    // Fairness with all requesters and done every grant cycle.
    do_reset(1);
    for (int i = 0; i < 9; i++) begin
      step("fair", 8'hFF, 1'b0);
      check("fair.seq", 32'(gnt_idx), 32'(i % 8));
      step("fair", 8'hFF, 1'b1);
    end

    // Wrap-around past 7.
    step("wrap", 8'h40, 1'b0);
    step("wrap", 8'h40, 1'b1);
    step("wrap", 8'h41, 1'b0);
    check("wrap.first", 32'(gnt_idx), 32'd0);
    step("wrap", 8'h41, 1'b1);
    step("wrap", 8'h41, 1'b0);
    check("wrap.second", 32'(gnt_idx), 32'd6);
    step("wrap", 8'h00, 1'b0);

    // Timeout, then done coinciding with timeout.
    step("idle", 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) step("tmo", 8'h04, 1'b0);
    step("tmo", 8'h04, 1'b0);
    check("tmo.pulse", 32'(tmo), 32'd1);
    step("tmo", 8'h04, 1'b0);
    check("tmo.regrant", 32'(gnt), 32'h04);
    for (int i = 0; i < 3; i++) step("tmo2", 8'h04, 1'b0);
    step("tmo2", 8'h04, 1'b1);
    check("tmo2.quiet", 32'(tmo), 32'd0);
    step("tmo2", 8'h00, 1'b0);

    // Async reset in the middle of a grant.
    do_reset(1);
    step("arst", 8'h08, 1'b0);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    compare_all("arst.async");
    @(negedge clk);
    rst = 1'b0;
    step("arst", 8'hFF, 1'b0);
    check("arst.first", 32'(gnt_idx), 32'd0);

    // Abandonment.
    step("aband", 8'hFE, 1'b0);
    check("aband.tmo", 32'(tmo), 32'd0);
    step("aband", 8'h00, 1'b0);

    // Randomized traffic.
    cur = 8'h00;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(3) == 0) cur = 8'($urandom);
      if ($urandom_range(15) == 0) cur[$urandom_range(7)] = 1'b0;
      step("rand", cur, $urandom_range(5) == 0);
      if (n == 300) begin
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        compare_all("rand.arst");
        @(negedge clk);
        rst = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/arbiter8_rr.md
# arbiter8_rr

Round-robin arbiter that shares one 8-way decoded resource among eight requesters. It picks one active request, holds the grant until the holder releases it or a hold timeout expires, then rotates priority. `gnt_idx`/`gnt_en` connect directly to the `din`/`en` pair of the team's 3-to-8 decoder. `gnt` provides the same selection as a registered one-hot vector for local use.

## Interface
- `HOLD_MAX`, default 16: maximum cycles a grant may be held; 0 disables the timeout; legal range 0..255.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `req`  in  8  request lines; bit i = requester i.
- `done`  in  1  current holder releases the grant.
- `gnt_idx`  out  3  index of the granted requester (decoder `din`).
- `gnt_en`  out  1  grant valid (decoder enable).
- `gnt`  out  8  one-hot grant; equals `1 << gnt_idx` when `gnt_en`=1, else 0.
- `tmo`  out  1  one-cycle pulse: the last grant was ended by timeout.

## Operation
- State machine has two states:
  - IDLE: `gnt_en`=0.
  - GRANT: `gnt_en`=1.
- Internal registers:
  - 3-bit priority pointer `ptr`.
  - 8-bit hold counter `cnt`.
- IDLE, `req`=0: stay in IDLE.
- IDLE, `req`≠0:
  - Search `req` starting at bit `ptr`, ascending, wrapping 7→0.
  - The first set bit k wins.
  - At the edge: go to GRANT, `gnt_idx`=k, `gnt`=1<<k, `cnt`=0, `ptr`=(k+1) mod 8.
- GRANT: `cnt` increments each cycle, saturating at 255. Release conditions, evaluated at each edge:
  - `done`=1: go to IDLE, `tmo`=0.
  - `req[gnt_idx]`=0 (requester abandoned): go to IDLE, `tmo`=0.
  - `HOLD_MAX`≠0 and `cnt`==`HOLD_MAX`-1 and neither of the above: go to IDLE, `tmo`=1 for the following cycle.
  - `done` and timeout on the same edge: treated as a normal release, `tmo`=0.
- Every release passes through at least one IDLE cycle. This gives break-before-make on the decoder outputs, and no two `gnt` bits are ever high together.
- `gnt_idx` keeps the last granted index while in IDLE. `gnt` is 0 in IDLE.
- `req` changes during GRANT on bits other than `gnt_idx` have no effect until the next arbitration.
- Pointer rotation guarantees any continuously asserted requester is granted within 8 grants.

## Timing
- All outputs are registered.
- Reset values: `gnt_idx`=0, `gnt_en`=0, `gnt`=0, `tmo`=0. Internal: state=IDLE, `ptr`=0, `cnt`=0.
- Reset asserted mid-grant: outputs clear immediately (asynchronously), without waiting for a clock. The first arbitration after release starts from `ptr`=0.
- Grant latency: `req` high before edge n while in IDLE → `gnt_en`=1 after edge n.
- Release latency: `done` high before edge m while in GRANT → `gnt_en`=0 after edge m.
- Minimum gap between consecutive grants: 1 cycle (IDLE).
- Maximum grant length with timeout enabled: exactly `HOLD_MAX` cycles of `gnt_en`=1.
- `tmo`:
  - High for exactly the one IDLE cycle after a timeout release.
  - If `req` remains set, the next grant follows on the edge that ends that cycle.
- `done` is ignored in IDLE.

## Test plan
- Reset: assert `rst` with random `req`/`done` → `gnt_idx`=0, `gnt_en`=0, `gnt`=0x00, `tmo`=0 during reset and until the first `req`.
- Single requester: `req`=0x20, `done` pulsed on the 3rd grant cycle → after 1 cycle `gnt_idx`=5, `gnt`=0x20. `gnt_en` is high exactly 3 cycles, then 1 IDLE cycle, then re-grant to 5.
- Fairness: `req`=0xFF, `done` pulsed on every grant cycle → grant sequence 0,1,2,…,7,0. Each grant lasts 1 cycle, separated by 1 IDLE cycle.
- Wrap-around: grant 6 completes, then `req`=0x41 → next grant is 0, then 6.
- Timeout with `HOLD_MAX`=4: `req`=0x04 held, `done`=0 → `gnt_en` high exactly 4 cycles, then `tmo`=1 for 1 cycle with `gnt_en`=0, then re-grant to 2. Repeat with `done`=1 on the 4th cycle → `tmo` stays 0.
- Reset and abandonment:
  - Assert `rst` asynchronously mid-grant (`gnt`=0x08) → `gnt`=0x00 before the next edge. After release with `req`=0xFF, the first grant is 0.
  - Drop `req[gnt_idx]` during a grant → release next edge, `tmo`=0.
